// File: rtl/count_sequence_checker.sv
// count_sequence_checker
// Receive-side monitor for a wrap-around binary counter sequence.
// It hunts for a legal value, confirms LOCK_N correct successors, then tracks
// the sequence with a flywheel prediction. While locked it flags every
// deviation with a one-cycle err_pulse and a saturating 8-bit err_count.
// LOSS_N consecutive misses drop lock and return the checker to HUNT.
//
// Optional feature: define COUNT_SEQUENCE_CHECKER_STALL_EN to treat a sample
// that repeats the previous accepted sample as a stall instead of a mismatch
// (builds a WIDTH-bit last-sample register plus a valid flag).
module count_sequence_checker #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8,
  parameter int LOCK_N  = 2,
  parameter int LOSS_N  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_valid,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             resync,
  output logic             locked,
  output logic             err_pulse,
  output logic [7:0]       err_count,
  output logic [WIDTH-1:0] expected,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  // Counter width large enough to reach both LOCK_N and LOSS_N.
  localparam int CW = $clog2(((LOCK_N > LOSS_N) ? LOCK_N : LOSS_N) + 1);

  // One extra bit so that MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'(MODULUS - 1);
  localparam logic [CW-1:0]    LOCK_TGT = CW'(LOCK_N);
  localparam logic [CW-1:0]    LOSS_TGT = CW'(LOSS_N);

  // Wrap-around successor, evaluated WIDTH bits wide.
  function automatic logic [WIDTH-1:0] succ(input logic [WIDTH-1:0] v);
    if (v == LAST_VAL) begin
      return '0;
    end else begin
      return v + 1'b1;
    end
  endfunction

  state_t           state_reg;
  logic [WIDTH-1:0] expected_reg;
  logic [CW-1:0]    match_cnt_reg;
  logic [CW-1:0]    miss_cnt_reg;
  logic [7:0]       err_count_reg;
  logic             err_pulse_reg;

  logic             sample_legal;
  logic             sample_match;
  logic             is_repeat;
  logic [WIDTH-1:0] succ_in;
  logic [WIDTH-1:0] succ_exp;
  logic [CW-1:0]    match_inc;
  logic [CW-1:0]    miss_inc;
  logic [7:0]       err_count_sat;

  // Values at or beyond MODULUS can never be part of a valid sequence.
  assign sample_legal  = ({1'b0, cnt_in} < MOD_EXT);
  assign sample_match  = sample_legal && (cnt_in == expected_reg);
  assign succ_in       = succ(cnt_in);
  assign succ_exp      = succ(expected_reg);
  assign match_inc     = match_cnt_reg + 1'b1;
  assign miss_inc      = miss_cnt_reg + 1'b1;
  assign err_count_sat = (err_count_reg == 8'hFF) ? err_count_reg : err_count_reg + 8'd1;

`ifdef COUNT_SEQUENCE_CHECKER_STALL_EN
  logic [WIDTH-1:0] last_reg;
  logic             last_valid_reg;

  // A repeat of the last accepted sample means the counter paused.
  assign is_repeat = last_valid_reg && (cnt_in == last_reg);

  // Remember the most recent accepted sample for stall detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg       <= '0;
      last_valid_reg <= 1'b0;
    end else if (cnt_valid && !resync) begin
      last_reg       <= cnt_in;
      last_valid_reg <= 1'b1;
    end
  end
`else
  // Without stall support a repeated value is just another mismatch.
  assign is_repeat = 1'b0;
`endif

  // Lock FSM with flywheel prediction, error pulse and saturating tally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= HUNT;
      expected_reg  <= '0;
      match_cnt_reg <= '0;
      miss_cnt_reg  <= '0;
      err_count_reg <= '0;
      err_pulse_reg <= 1'b0;
    end else begin
      // The pulse lasts exactly one cycle unless re-armed below.
      err_pulse_reg <= 1'b0;
      if (resync) begin
        // Resync wins over any sample presented in the same cycle.
        state_reg     <= HUNT;
        match_cnt_reg <= '0;
        miss_cnt_reg  <= '0;
      end else if (cnt_valid) begin
        case (state_reg)
          HUNT: begin
            if (sample_legal) begin
              expected_reg  <= succ_in;
              match_cnt_reg <= '0;
              state_reg     <= CONFIRM;
            end
          end
          CONFIRM: begin
            if (is_repeat) begin
              // Counter paused: keep the current candidate untouched.
              state_reg <= CONFIRM;
            end else if (sample_match) begin
              match_cnt_reg <= match_inc;
              expected_reg  <= succ_in;
              if (match_inc == LOCK_TGT) begin
                state_reg <= LOCKED;
              end
            end else if (sample_legal) begin
              // Legal but wrong: restart confirmation from this value.
              expected_reg  <= succ_in;
              match_cnt_reg <= '0;
            end else begin
              match_cnt_reg <= '0;
              state_reg     <= HUNT;
            end
          end
          LOCKED, LOST: begin
            if (is_repeat) begin
              // Stall: prediction and counters hold.
              state_reg <= state_reg;
            end else if (sample_match) begin
              expected_reg <= succ_exp;
              miss_cnt_reg <= '0;
              state_reg    <= LOCKED;
            end else begin
              // Flywheel: keep advancing the prediction through errors.
              err_pulse_reg <= 1'b1;
              err_count_reg <= err_count_sat;
              expected_reg  <= succ_exp;
              if (state_reg == LOCKED) begin
                miss_cnt_reg <= CW'(1);
                state_reg    <= LOST;
              end else if (miss_inc == LOSS_TGT) begin
                miss_cnt_reg <= '0;
                state_reg    <= HUNT;
              end else begin
                miss_cnt_reg <= miss_inc;
              end
            end
          end
          default: begin
            state_reg <= HUNT;
          end
        endcase
      end
    end
  end

  assign state     = state_reg;
  assign locked    = state_reg[1];
  assign err_pulse = err_pulse_reg;
  assign err_count = err_count_reg;
  assign expected  = expected_reg;

endmodule
